// File: rtl/asterix_pkg.sv
// Shared constants and types for the scanline-to-UART packet path.
package asterix_pkg;

    localparam int         SL_BITS   = 160;
    localparam int         NUM_LINES = 68;
    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    // Data bytes carried by one packet.
    localparam int         SL_BYTES  = SL_BITS / 8;

    // Packet sequencer states, in byte order on the wire.
    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_LINE,
        S_DATA,
        S_CSUM
    } seq_state_e;

endpackage

// File: rtl/scanline_packet_sequencer.sv
// Pops one scanline from a show-ahead FIFO and streams it to the UART as
// SYNC, line index, SL_BITS/8 data bytes (MSB first) and an XOR checksum
// over the line and data bytes. Also tracks line and frame position.
module scanline_packet_sequencer #(
    parameter int         SL_BITS   = asterix_pkg::SL_BITS,
    parameter int         NUM_LINES = asterix_pkg::NUM_LINES,
    parameter logic [7:0] SYNC_BYTE = asterix_pkg::SYNC_BYTE
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               fifo_empty,
    input  logic [SL_BITS-1:0] fifo_q,
    output logic               fifo_ack,
    output logic [7:0]         tx_data,
    output logic               tx_valid,
    input  logic               tx_ready,
    output logic [7:0]         line_idx,
    output logic [7:0]         frame_cnt,
    output logic               pkt_done
);
    import asterix_pkg::*;

    localparam int               N_BYTES   = SL_BITS / 8;
    localparam int               CNT_W     = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(N_BYTES - 1);
    localparam logic [7:0]       LAST_LINE = 8'(NUM_LINES - 1);

    seq_state_e         state_q;
    logic [SL_BITS-1:0] shreg_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [7:0]         csum_q;
    logic [7:0]         tx_data_q;
    logic               tx_valid_q;
    logic [7:0]         line_idx_q;
    logic [7:0]         frame_cnt_q;
    logic               pkt_done_q;
    logic               armed_q;
    logic               start;
    logic               accept;

    // Pop only from IDLE, never during or right out of reset, and never in the
    // pkt_done cycle, which guarantees one idle cycle between packets.
    // NOTE: plain continuous assigns are fully specified, so no latch can appear.
    assign start  = armed_q && (state_q == S_IDLE) && !pkt_done_q && enable && !fifo_empty;
    assign accept = tx_valid_q && tx_ready;

    // fifo_ack is the FIFO rdreq: high in the same cycle the head is latched.
    assign fifo_ack  = start;
    assign tx_data   = tx_data_q;
    assign tx_valid  = tx_valid_q;
    assign line_idx  = line_idx_q;
    assign frame_cnt = frame_cnt_q;
    assign pkt_done  = pkt_done_q;

    // Packet FSM: each byte is loaded onto the registered tx outputs, held
    // until accepted, then the next byte is loaded one cycle later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            // NOTE: the shift register is ordinary flops, not RAM, so it is cleared with the rest.
            shreg_q     <= '0;
            cnt_q       <= '0;
            csum_q      <= 8'h00;
            tx_data_q   <= 8'h00;
            tx_valid_q  <= 1'b0;
            line_idx_q  <= 8'h00;
            frame_cnt_q <= 8'h00;
            pkt_done_q  <= 1'b0;
            armed_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every branch sees start-of-cycle values.
            armed_q    <= 1'b1;
            pkt_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        shreg_q    <= fifo_q;
                        tx_data_q  <= SYNC_BYTE;
                        tx_valid_q <= 1'b1;
                        state_q    <= S_SYNC;
                    end
                end
                S_SYNC: begin
                    if (accept) begin
                        tx_valid_q <= 1'b0;
                        state_q    <= S_LINE;
                    end
                end
                S_LINE: begin
                    if (!tx_valid_q) begin
                        tx_data_q  <= line_idx_q;
                        csum_q     <= line_idx_q;
                        tx_valid_q <= 1'b1;
                    end else if (accept) begin
                        tx_valid_q <= 1'b0;
                        cnt_q      <= '0;
                        state_q    <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (!tx_valid_q) begin
                        tx_data_q  <= shreg_q[SL_BITS-1 -: 8];
                        tx_valid_q <= 1'b1;
                    end else if (accept) begin
                        tx_valid_q <= 1'b0;
                        csum_q     <= csum_q ^ tx_data_q;
                        shreg_q    <= shreg_q << 8;
                        cnt_q      <= cnt_q + 1'b1;
                        if (cnt_q == LAST_BYTE) begin
                            state_q <= S_CSUM;
                        end
                    end
                end
                S_CSUM: begin
                    if (!tx_valid_q) begin
                        tx_data_q  <= csum_q;
                        tx_valid_q <= 1'b1;
                    end else if (accept) begin
                        tx_valid_q <= 1'b0;
                        pkt_done_q <= 1'b1;
                        if (line_idx_q == LAST_LINE) begin
                            line_idx_q  <= 8'h00;
                            frame_cnt_q <= frame_cnt_q + 8'h01;
                        end else begin
                            line_idx_q  <= line_idx_q + 8'h01;
                        end
                        state_q    <= S_IDLE;
                    end
                end
                default: begin
                    tx_valid_q <= 1'b0;
                    state_q    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scanline_packet_sequencer.sv
// Self-checking bench: random scanlines and random UART back-pressure,
// compared against a byte-level packet model built from the framing rules.
module tb_scanline_packet_sequencer;
    import asterix_pkg::*;

    logic               clk;
    logic               reset;
    logic               enable;
    logic               fifo_empty;
    logic [SL_BITS-1:0] fifo_q;
    logic               fifo_ack;
    logic [7:0]         tx_data;
    logic               tx_valid;
    logic               tx_ready;
    logic [7:0]         line_idx;
    logic [7:0]         frame_cnt;
    logic               pkt_done;

    scanline_packet_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .fifo_empty (fifo_empty),
        .fifo_q     (fifo_q),
        .fifo_ack   (fifo_ack),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .line_idx   (line_idx),
        .frame_cnt  (frame_cnt),
        .pkt_done   (pkt_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int exp_line = 0;
    int exp_frame = 0;
    int total_pkts = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    function automatic logic [SL_BITS-1:0] rand_line();
        logic [SL_BITS-1:0] v;
        for (int i = 0; i < SL_BITS / 32 + 1; i++) begin
            v = {v[SL_BITS-33:0], $urandom()};
        end
        return v;
    endfunction

    // Sends one scanline and compares the accepted byte stream with the model.
    task automatic run_packet(input logic [SL_BITS-1:0] sl, input bit rand_ready,
                              input int drop_en_at, input bit keep_full, input string tag);
        int         acks;
        int         dones;
        bit         stall_prev;
        bit         ack_seen;
        logic [7:0] stall_data;
        logic [7:0] cs;
        logic [7:0] b;
        int         n;

        // Reference packet from the framing rules.
        exp_q = {};
        exp_q.push_back(SYNC_BYTE);
        exp_q.push_back(8'(exp_line));
        cs = 8'(exp_line);
        for (int i = 0; i < SL_BYTES; i++) begin
            b = sl[SL_BITS - 1 - 8 * i -: 8];
            exp_q.push_back(b);
            cs = cs ^ b;
        end
        exp_q.push_back(cs);

        got_q      = {};
        fifo_q     = sl;
        fifo_empty = 1'b0;
        tx_ready   = rand_ready ? ($urandom_range(3) == 0) : 1'b1;
        acks       = 0;
        dones      = 0;
        stall_prev = 1'b0;
        stall_data = 8'h00;

        for (int cyc = 0; cyc < 3000 && dones == 0; cyc++) begin
            @(negedge clk);
            if (stall_prev) begin
                n_checks++;
                if (tx_valid !== 1'b1 || tx_data !== stall_data) begin
                    n_errors++;
                    $display("FAIL %s hold: valid=%b data=%02h required valid=1 data=%02h",
                             tag, tx_valid, tx_data, stall_data);
                end
            end
            stall_prev = (tx_valid === 1'b1) && (tx_ready === 1'b0);
            stall_data = tx_data;
            ack_seen   = (fifo_ack === 1'b1);
            if (ack_seen) acks++;
            if (pkt_done === 1'b1) dones++;
            if (tx_valid === 1'b1 && tx_ready === 1'b1) got_q.push_back(tx_data);
            if (drop_en_at >= 0 && got_q.size() == drop_en_at) enable = 1'b0;
            @(posedge clk);
            #1;
            if (ack_seen && !keep_full) fifo_empty = 1'b1;
            if (rand_ready) tx_ready = ($urandom_range(3) == 0);
        end
        tx_ready = 1'b1;

        n_checks++;
        if (dones != 1) begin
            n_errors++;
            $display("FAIL %s pkt_done: got %0d pulses, required 1 (timeout?)", tag, dones);
        end
        n_checks++;
        if (acks != 1) begin
            n_errors++;
            $display("FAIL %s fifo_ack: got %0d pulses, required 1", tag, acks);
        end
        n_checks++;
        if (got_q.size() != exp_q.size()) begin
            n_errors++;
            $display("FAIL %s length: got %0d bytes, required %0d", tag, got_q.size(), exp_q.size());
        end
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_errors++;
                $display("FAIL %s byte %0d: got %02h, required %02h", tag, i, got_q[i], exp_q[i]);
            end
        end

        // Line/frame position after the packet.
        if (dones == 1) begin
            total_pkts++;
            if (exp_line == NUM_LINES - 1) begin
                exp_line  = 0;
                exp_frame = (exp_frame + 1) % 256;
            end else begin
                exp_line = exp_line + 1;
            end
        end
        n_checks++;
        if (line_idx !== 8'(exp_line) || frame_cnt !== 8'(exp_frame)) begin
            n_errors++;
            $display("FAIL %s position: line_idx=%0d frame_cnt=%0d, required %0d/%0d",
                     tag, line_idx, frame_cnt, exp_line, exp_frame);
        end
    endtask

    task automatic test_reset();
        reset      = 1'b0;
        enable     = 1'b1;
        fifo_empty = 1'b0;
        fifo_q     = rand_line();
        tx_ready   = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({fifo_ack, tx_valid, pkt_done, tx_data, line_idx, frame_cnt} !== '0) begin
            n_errors++;
            $display("FAIL reset_state: ack=%b valid=%b done=%b data=%02h line=%02h frame=%02h, required all 0",
                     fifo_ack, tx_valid, pkt_done, tx_data, line_idx, frame_cnt);
        end
        fifo_empty = 1'b1;
        reset      = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        run_packet(160'h0102030405060708090A0B0C0D0E0F1011121314, 1'b0, -1, 1'b0, "single");
        n_checks++;
        if (got_q.size() != SL_BYTES + 3 || got_q[SL_BYTES + 2] !== 8'h14) begin
            n_errors++;
            $display("FAIL single_csum: got %0d bytes, last=%02h, required 23 bytes ending 14",
                     got_q.size(), (got_q.size() > 0) ? got_q[got_q.size() - 1] : 8'hxx);
        end
    endtask

    task automatic test_all_ones();
        while (exp_line < 5) run_packet(rand_line(), 1'b0, -1, 1'b0, "preload");
        run_packet({SL_BITS{1'b1}}, 1'b0, -1, 1'b0, "all_ones");
        n_checks++;
        if (got_q.size() != SL_BYTES + 3 || got_q[1] !== 8'h05 || got_q[SL_BYTES + 2] !== 8'h05) begin
            n_errors++;
            $display("FAIL all_ones_frame: got %0d bytes, line/csum not both 05", got_q.size());
        end
    endtask

    task automatic test_stall();
        run_packet(rand_line(), 1'b1, -1, 1'b0, "stall_a");
        run_packet(rand_line(), 1'b1, -1, 1'b0, "stall_b");
    endtask

    task automatic test_frame_wrap();
        while (total_pkts < NUM_LINES + 1) begin
            run_packet(rand_line(), total_pkts[0], -1, 1'b0, "wrap");
        end
        n_checks++;
        if (frame_cnt !== 8'd1 || line_idx !== 8'd1) begin
            n_errors++;
            $display("FAIL frame_wrap: frame_cnt=%0d line_idx=%0d, required 1/1", frame_cnt, line_idx);
        end
    endtask

    task automatic test_enable();
        int acks;
        int valids;
        enable     = 1'b0;
        fifo_q     = rand_line();
        fifo_empty = 1'b0;
        acks       = 0;
        valids     = 0;
        repeat (30) begin
            @(negedge clk);
            if (fifo_ack === 1'b1) acks++;
            if (tx_valid === 1'b1) valids++;
        end
        n_checks++;
        if (acks != 0 || valids != 0) begin
            n_errors++;
            $display("FAIL enable_low: got %0d acks %0d valid cycles, required 0/0", acks, valids);
        end
        @(posedge clk);
        #1;
        enable = 1'b1;
        // Drop enable after 6 accepted bytes (inside DATA), FIFO stays non-empty.
        run_packet(rand_line(), 1'b0, 6, 1'b1, "enable_drop");
        acks = 0;
        repeat (30) begin
            @(negedge clk);
            if (fifo_ack === 1'b1) acks++;
        end
        n_checks++;
        if (acks != 0) begin
            n_errors++;
            $display("FAIL enable_drop_next: got %0d acks after packet, required 0", acks);
        end
        fifo_empty = 1'b1;
        enable     = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        int  accepted;
        int  acks;
        bit  hit;
        bit  ack_seen;
        fifo_q     = rand_line();
        fifo_empty = 1'b0;
        tx_ready   = 1'b1;
        accepted   = 0;
        acks       = 0;
        hit        = 1'b0;
        for (int cyc = 0; cyc < 500 && !hit; cyc++) begin
            @(negedge clk);
            ack_seen = (fifo_ack === 1'b1);
            if (ack_seen) acks++;
            if (tx_valid === 1'b1 && accepted == 9) begin
                // Data byte 7 is on the bus: abort asynchronously mid-cycle.
                hit = 1'b1;
                #2;
                reset = 1'b0;
                #1;
                n_checks++;
                if ({fifo_ack, tx_valid, pkt_done, tx_data, line_idx, frame_cnt} !== '0) begin
                    n_errors++;
                    $display("FAIL reset_mid: ack=%b valid=%b done=%b data=%02h line=%02h frame=%02h, required all 0",
                             fifo_ack, tx_valid, pkt_done, tx_data, line_idx, frame_cnt);
                end
            end else begin
                if (tx_valid === 1'b1 && tx_ready === 1'b1) accepted++;
                @(posedge clk);
                #1;
                if (ack_seen) fifo_empty = 1'b1;
            end
        end
        n_checks++;
        if (!hit || acks != 1) begin
            n_errors++;
            $display("FAIL reset_mid_reach: reached=%0b acks=%0d, required 1/1", hit, acks);
        end
        fifo_empty = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset     = 1'b1;
        exp_line  = 0;
        exp_frame = 0;
        @(posedge clk);
        #1;
        run_packet(rand_line(), 1'b0, -1, 1'b0, "after_reset");
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_ones();
        test_stall();
        test_frame_wrap();
        test_enable();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
